spi_flash_cmd_ctrl: RTL and testbench

Command sequencer between `spi_ip_core` and `memory` inside `spi_flash_memory`. It decodes the byte stream received over SPI into flash-style commands (write enable/disable, read status, read, page program), drives the memory array's address/data/strobe signals, and supplies response bytes back to the SPI core for MISO. It also owns the status register: write-enable latch (WEL) and write-in-progress (WIP). WIP emulates program busy time with a cycle counter.

---
 rtl/spi_flash_cmd_ctrl.sv | 178 +++++++++++++++++
 tb/tb_spi_flash_cmd_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_cmd_ctrl.sv
// spi_flash_cmd_ctrl: decodes SPI flash commands and drives the memory array.
// Owns the WEL/WIP status bits and emulates program busy time with a counter.
// Define SPI_FLASH_FAST_READ_EN to decode 0x0B FAST_READ, which reads after one dummy byte.
module spi_flash_cmd_ctrl #(
   parameter int ADDR_BYTES  = 2,
   parameter int PAGE_BITS   = 8,
   parameter int PROG_CYCLES = 64
) (
   input  logic                    clk,
   input  logic                    RESET,
   input  logic                    S,
   input  logic [7:0]              RX_DATA,
   input  logic                    RX_VALID,
   output logic [7:0]              TX_DATA,
   output logic                    TX_LOAD,
   output logic [8*ADDR_BYTES-1:0] MEM_ADDR,
   output logic [7:0]              MEM_D,
   output logic                    MEM_WE,
   output logic                    MEM_RE,
   input  logic [7:0]              MEM_Q,
   output logic                    BUSY
);
   localparam int AW = 8*ADDR_BYTES;
   localparam int CW = $clog2(PROG_CYCLES+1);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, READ, PROG, STATUS, IGNORE
`ifdef SPI_FLASH_FAST_READ_EN
      , DUMMY
`endif
   } state_t;

   state_t          r_state, w_nxt;
   logic [1:0]      r_sync;
   logic            r_s_d, w_s, w_fall, w_rise, w_rx, w_last;
   logic            w_re, w_we, w_txl;
   logic            r_re, r_we, r_txl, r_ld_mem;
   logic [7:0]      r_tx, r_d, r_op;
   logic [AW-1:0]   r_addr;
   logic [3:0]      r_bcnt;
   logic            r_wel, r_wip, r_wrote;
   logic [1:0]      r_pend;
   logic [CW-1:0]   r_cnt;

   assign w_s      = r_sync[1];
   assign w_fall   = r_s_d & ~w_s;
   assign w_rise   = ~r_s_d & w_s;
   assign w_rx     = RX_VALID & ~w_rise;
   assign w_last   = r_bcnt == 4'(ADDR_BYTES-1);
   assign TX_DATA  = r_ld_mem ? MEM_Q : r_tx;
   assign TX_LOAD  = r_txl;
   assign MEM_ADDR = r_addr;
   assign MEM_D    = r_d;
   assign MEM_WE   = r_we;
   assign MEM_RE   = r_re;
   assign BUSY     = r_wip;

   // two-flop chip-select synchroniser plus edge history; idles high (deselected)
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_sync <= 2'b11;
         r_s_d  <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], S};
         r_s_d  <= w_s;
      end
   end

   // command state register
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) r_state <= IDLE;
      else        r_state <= w_nxt;
   end

   // next state and one-cycle strobe requests; a chip-select rise aborts any frame
   always_comb begin
      w_nxt = r_state;
      w_re  = 1'b0;
      w_we  = 1'b0;
      w_txl = 1'b0;
      if (w_rise) w_nxt = IDLE;
      else case (r_state)
         IDLE: if (w_fall) w_nxt = CMD;
         CMD: if (w_rx) begin
            if (RX_DATA == 8'h05) begin
               w_nxt = STATUS;
               w_txl = 1'b1;
            end else if (r_wip) w_nxt = IGNORE;
            else if (RX_DATA == 8'h03 || (RX_DATA == 8'h02 && r_wel)) w_nxt = ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
            else if (RX_DATA == 8'h0B) w_nxt = ADDR;
`endif
            else w_nxt = IGNORE;
         end
         ADDR: if (w_rx && w_last) begin
`ifdef SPI_FLASH_FAST_READ_EN
            if (r_op == 8'h0B) w_nxt = DUMMY; else
`endif
            if (r_op == 8'h03) begin
               w_nxt = READ;
               w_re  = 1'b1;
            end else w_nxt = PROG;
         end
`ifdef SPI_FLASH_FAST_READ_EN
         DUMMY: if (w_rx) begin
            w_nxt = READ;
            w_re  = 1'b1;
         end
`endif
         READ:    w_re  = w_rx;
         PROG:    w_we  = w_rx;
         STATUS:  w_txl = w_rx;
         default: ;
      endcase
   end

   // memory strobes, address/data registers and the MISO byte path
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_re     <= 1'b0;
         r_we     <= 1'b0;
         r_txl    <= 1'b0;
         r_ld_mem <= 1'b0;
         r_tx     <= '0;
         r_d      <= '0;
         r_op     <= '0;
         r_addr   <= '0;
         r_bcnt   <= '0;
      end else begin
         r_re     <= w_re;
         r_we     <= w_we;
         r_ld_mem <= r_re;
         r_txl    <= w_txl | r_re;
         if (w_txl) r_tx <= {6'b0, r_wel, r_wip};
         else if (r_ld_mem) r_tx <= MEM_Q;
         if (w_we) r_d <= RX_DATA;
         if (r_state == CMD && w_rx) begin
            r_op   <= RX_DATA;
            r_bcnt <= '0;
         end
         if (r_state == ADDR && w_rx) begin
            r_addr <= AW'({r_addr, RX_DATA});
            r_bcnt <= r_bcnt + 4'd1;
         end else if (r_state == READ && w_re) r_addr <= r_addr + AW'(1);
         else if (r_state == PROG && r_we) r_addr[PAGE_BITS-1:0] <= r_addr[PAGE_BITS-1:0] + PAGE_BITS'(1);
      end
   end

   // status register: WEL/WIP updates at frame end and the program busy countdown
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         r_wel   <= 1'b0;
         r_wip   <= 1'b0;
         r_cnt   <= '0;
         r_pend  <= '0;
         r_wrote <= 1'b0;
      end else begin
         if (r_wip) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_wip <= 1'b0;
         end
         if (r_state == CMD && w_rx) begin
            r_pend  <= {~r_wip & (RX_DATA == 8'h06 || RX_DATA == 8'h04), RX_DATA == 8'h06};
            r_wrote <= 1'b0;
         end else if (r_state == IGNORE && w_rx) r_pend <= '0;
         if (w_we) r_wrote <= 1'b1;
         if (w_rise) begin
            r_pend  <= '0;
            r_wrote <= 1'b0;
            if (r_wrote) begin
               r_wip <= 1'b1;
               r_cnt <= CW'(PROG_CYCLES);
               r_wel <= 1'b0;
            end else if (r_pend[1]) r_wel <= r_pend[0];
         end
      end
   end
endmodule

// File: tb/tb_spi_flash_cmd_ctrl.sv
// tb_spi_flash_cmd_ctrl: directed scoreboard bench for spi_flash_cmd_ctrl.
module tb_spi_flash_cmd_ctrl;
   logic        clk = 1'b0, RESET, S, RX_VALID;
   logic [7:0]  RX_DATA, TX_DATA, MEM_D, MEM_Q = 8'h00;
   logic        TX_LOAD, MEM_WE, MEM_RE, BUSY;
   logic [15:0] MEM_ADDR;
   int          cyc = 0, vectors = 0, miscompares = 0;

   typedef struct {logic [15:0] a; logic [7:0] d; int c;} exp_t;
   exp_t q_re[$], q_we[$], q_tx[$];
   exp_t e;
   logic [7:0] mem [0:65535];

   localparam int NONE = 0, RD = 1, WR = 2, ST = 3;

   spi_flash_cmd_ctrl dut (
      .clk(clk), .RESET(RESET), .S(S), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
      .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .MEM_ADDR(MEM_ADDR), .MEM_D(MEM_D),
      .MEM_WE(MEM_WE), .MEM_RE(MEM_RE), .MEM_Q(MEM_Q), .BUSY(BUSY)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pat(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic exp_t mk(input logic [15:0] a, input logic [7:0] d, input int c);
      exp_t x;
      x.a = a;
      x.d = d;
      x.c = c;
      return x;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // memory array model: registered read, valid the cycle after MEM_RE
   always @(posedge clk) begin
      if (MEM_WE) mem[MEM_ADDR] <= MEM_D;
      if (MEM_RE) MEM_Q <= mem[MEM_ADDR];
   end

   // scoreboard: every strobe must match the oldest pending expectation
   always @(negedge clk) if (RESET === 1'b1) begin
      if (MEM_RE) begin
         check("re_expected", 64'(q_re.size() > 0), 64'd1);
         if (q_re.size() > 0) begin
            e = q_re.pop_front();
            check("re_addr", 64'(MEM_ADDR), 64'(e.a));
            check("re_cycle", 64'(cyc), 64'(e.c));
         end
      end
      if (MEM_WE) begin
         check("we_expected", 64'(q_we.size() > 0), 64'd1);
         if (q_we.size() > 0) begin
            e = q_we.pop_front();
            check("we_addr", 64'(MEM_ADDR), 64'(e.a));
            check("we_data", 64'(MEM_D), 64'(e.d));
            check("we_cycle", 64'(cyc), 64'(e.c));
         end
      end
      if (TX_LOAD) begin
         check("tx_expected", 64'(q_tx.size() > 0), 64'd1);
         if (q_tx.size() > 0) begin
            e = q_tx.pop_front();
            check("tx_data", 64'(TX_DATA), 64'(e.d));
            check("tx_cycle", 64'(cyc), 64'(e.c));
         end
      end
   end

   task automatic frame_begin();
      @(negedge clk) S = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic frame_end();
      @(negedge clk) S = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b, input int kind = NONE, input logic [15:0] a = 16'h0, input logic [7:0] d = 8'h0);
      @(negedge clk);
      RX_DATA  = b;
      RX_VALID = 1'b1;
      case (kind)
         RD: begin
            q_re.push_back(mk(a, 8'h00, cyc + 1));
            q_tx.push_back(mk(16'h0, d, cyc + 2));
         end
         WR:      q_we.push_back(mk(a, d, cyc + 1));
         ST:      q_tx.push_back(mk(16'h0, d, cyc + 1));
         default: ;
      endcase
      @(negedge clk) RX_VALID = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic rdsr(input logic [7:0] exp);
      frame_begin();
      send(8'h05, ST, 16'h0, exp);
      frame_end();
   endtask

   task automatic wait_busy(input logic level, input int exp_cyc, input string tag);
      int n = 0;
      while (BUSY !== level && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(cyc), 64'(exp_cyc));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
      RESET = 1'b1; S = 1'b1; RX_VALID = 1'b0; RX_DATA = 8'h00;
      #1 RESET = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({TX_DATA, TX_LOAD, MEM_ADDR, MEM_D, MEM_WE, MEM_RE, BUSY}), 64'h0);
      RESET = 1'b1;
      repeat (3) @(negedge clk);
      rdsr(8'h00);
      // WREN then WRDI, and WREN followed by a stray byte
      frame_begin(); send(8'h06); frame_end();
      rdsr(8'h02);
      frame_begin(); send(8'h04); frame_end();
      rdsr(8'h00);
      frame_begin(); send(8'h06); send(8'h00); frame_end();
      rdsr(8'h00);
      // page program without WEL must not write
      frame_begin(); send(8'h02); send(8'h00); send(8'h10); send(8'h55); frame_end();
      check("busy_after_pp_no_wel", 64'(BUSY), 64'd0);
      rdsr(8'h00);
      // program with page wrap, then busy window
      frame_begin(); send(8'h06); frame_end();
      frame_begin();
      send(8'h02); send(8'h12); send(8'hFE);
      send(8'hAA, WR, 16'h12FE, 8'hAA);
      send(8'hBB, WR, 16'h12FF, 8'hBB);
      send(8'hCC, WR, 16'h1200, 8'hCC);
      @(negedge clk) S = 1'b1;
      k = cyc;
      wait_busy(1'b1, k + 3, "busy_rise_cycle");
      frame_begin(); send(8'h06); frame_end();
      frame_begin(); send(8'h05, ST, 16'h0, 8'h01); send(8'h00, ST, 16'h0, 8'h01); frame_end();
      wait_busy(1'b0, k + 67, "busy_fall_cycle");
      rdsr(8'h00);
      // read back across the page end and on into the next page
      frame_begin();
      send(8'h03); send(8'h12);
      send(8'hFE, RD, 16'h12FE, 8'hAA);
      send(8'h00, RD, 16'h12FF, 8'hBB);
      send(8'h00, RD, 16'h1300, pat(16'h1300));
      frame_end();
      // read wrapping over the top of the address space
      frame_begin();
      send(8'h03); send(8'hFF);
      send(8'hFF, RD, 16'hFFFF, pat(16'hFFFF));
      send(8'h00, RD, 16'h0000, pat(16'h0000));
      send(8'h00, RD, 16'h0001, pat(16'h0001));
      frame_end();
      // frame aborted after one address byte
      frame_begin(); send(8'h03); send(8'h12); frame_end();
      rdsr(8'h00);
      // fast read
      frame_begin();
      send(8'h0B); send(8'h00);
`ifdef SPI_FLASH_FAST_READ_EN
      send(8'h10);
      send(8'h99, RD, 16'h0010, pat(16'h0010));
      send(8'h00, RD, 16'h0011, pat(16'h0011));
`else
      send(8'h10); send(8'h99); send(8'h00);
`endif
      frame_end();
      // reset in the middle of an address phase
      frame_begin(); send(8'h03); send(8'h20);
      @(negedge clk) RESET = 1'b0;
      #1 check("reset_mid_frame", 64'({TX_DATA, TX_LOAD, MEM_ADDR, MEM_D, MEM_WE, MEM_RE, BUSY}), 64'h0);
      @(negedge clk) S = 1'b1;
      repeat (3) @(negedge clk);
      RESET = 1'b1;
      repeat (4) @(negedge clk);
      rdsr(8'h00);
      // reset while a program is busy
      frame_begin(); send(8'h06); frame_end();
      frame_begin(); send(8'h02); send(8'h40); send(8'h00); send(8'h77, WR, 16'h4000, 8'h77); frame_end();
      check("busy_before_reset", 64'(BUSY), 64'd1);
      @(negedge clk) RESET = 1'b0;
      #1 check("reset_mid_busy", 64'({TX_DATA, TX_LOAD, MEM_ADDR, MEM_D, MEM_WE, MEM_RE, BUSY}), 64'h0);
      @(negedge clk) RESET = 1'b1;
      repeat (4) @(negedge clk);
      rdsr(8'h00);
      repeat (4) @(negedge clk);
      check("re_queue_drained", 64'(q_re.size()), 64'd0);
      check("we_queue_drained", 64'(q_we.size()), 64'd0);
      check("tx_queue_drained", 64'(q_tx.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
